if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//   Instruction-fetch stage for the lab05 CPU core, upstream of decode.
//   Holds the fetch PC and issues word reads to a 1-cycle-latency synchronous
//   instruction memory. Buffers returned words, each tagged with its PC, in a
//   small prefetch FIFO. Hands them to decode over a valid/ready handshake.
//   Branch/jump redirects from execute flush the buffer and restart fetch.
// PARAMETERS
//   PC_W      8      fetch PC width, byte address, wraps modulo 2^PC_W
//   INSN_W    32     instruction width
//   DEPTH     2      prefetch FIFO entries (power of 2, >=2)
//   RESET_PC  8'h00  PC loaded on reset; bits[1:0] must be 0
// PORTS
//   clk          in   1         rising-edge clock
//   rst_n        in   1         asynchronous, active-low reset
//   imem_req     out  1         read strobe to instruction memory
//   imem_addr    out  PC_W-2    word address = fetch_pc[PC_W-1:2]
//   imem_rdata   in   INSN_W    read data, valid exactly 1 cycle after imem_req
//   redirect     in   1         1-cycle pulse: restart fetch at redirect_pc
//   redirect_pc  in   PC_W      new fetch PC; bits[1:0] ignored (forced 0)
//   id_valid     out  1         FIFO head holds a valid instruction
//   id_ready     in   1         decode accepts the head this cycle
//   id_insc      out  INSN_W    head instruction; 0 when FIFO empty
//   id_pc        out  PC_W      PC of head instruction; 0 when FIFO empty
//   pc           out  PC_W      current fetch PC (next address to request)
// BEHAVIOUR
//   Reset (async on rst_n=0):
//     - pc=RESET_PC; imem_req=0; id_valid=0; id_insc=0; id_pc=0
//     - FIFO empty; in-flight flag=0; state=BOOT
//   FSM:
//     - BOOT: one idle cycle after reset release, no request; -> RUN
//     - RUN: normal fetch; redirect -> FLUSH
//     - FLUSH: exactly 1 cycle; no request; -> RUN
//   Request rule (RUN only, redirect=0):
//     - imem_req=1 when count + inflight - pop < DEPTH
//     - pop = id_valid & id_ready
//     - Each request: pc <= pc+4 (wraps 8'hFC -> 8'h00)
//     - Records in-flight PC; inflight <= 1 next cycle
//   Response: cycle after a request, push {inflight_pc, imem_rdata} unless killed.
//   Pop: on id_valid & id_ready, head leaves at the clock edge.
//     - Push and pop in the same cycle are both honoured; count unchanged.
//   Throughput: with id_ready held at 1, one instruction per cycle.
//   Latency: first id_valid occurs 2 cycles after the first imem_req.
//   Redirect (any state):
//     - pc <= {redirect_pc[PC_W-1:2],2'b00}; FIFO cleared; state -> FLUSH
//     - Response of an in-flight request is discarded (kill flag, not pushed)
//     - A handshake in the redirect cycle still completes (decode consumed it)
//     - id_valid=0 from the next cycle until new-path data returns
//   Redirect in FLUSH: latest redirect_pc wins; FLUSH repeats for 1 cycle.
//   id_ready=0 with FIFO full: requests stop, pc frozen, no data lost.
//   id_valid must not drop, and id_insc/id_pc must not change, while stalled
//   (except on redirect).
//   Reset mid-operation returns all state to reset values immediately.
// TESTING
//   1. Reset, release, id_ready=1, imem returns word at addr -> id_pc 00,04,08,...
//      back to back; first id_valid 3 cycles after release.
//   2. id_ready=0 for 5 cycles -> FIFO fills to 2 entries, imem_req=0, pc=08.
//      Release -> entries 00,04 popped in order, no duplicates or skips.
//   3. Redirect to 8'h41 while a request is in flight -> next imem_addr=0x10,
//      next id_pc=8'h40, killed word never presented.
//   4. Fetch at pc=8'hF8 with id_ready=1 -> id_pc sequence F8,FC,00,04 (wrap).
//   5. Redirect coincident with handshake of id_pc=0C -> 0C counted consumed,
//      id_valid=0 next cycle, FIFO empty.
//   6. Assert rst_n=0 mid-stream -> pc=00, id_valid=0 same cycle.
//      Restart matches scenario 1.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: drives a 1-cycle synchronous instruction memory,
// buffers {pc, insn} pairs in a small prefetch FIFO and hands them to decode.
module if_fetch_unit #(
    parameter int unsigned     PC_W     = 8,
    parameter int unsigned     INSN_W   = 32,
    parameter int unsigned     DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [PC_W-3:0]   imem_addr,
    input  logic [INSN_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [INSN_W-1:0] id_insc,
    output logic [PC_W-1:0]   id_pc,
    output logic [PC_W-1:0]   pc
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [INSN_W-1:0] fifo_insn [DEPTH];
    logic [PC_W-1:0]   fifo_pc   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              inflight;
    logic [PC_W-1:0]   inflight_pc;
    logic              pop, push;
    logic [OCC_W-1:0]  occupancy;

    // Head-of-FIFO presentation; zeroed when nothing is buffered
    assign id_valid  = (count != '0);
    assign id_insc   = id_valid ? fifo_insn[rd_ptr] : '0;
    assign id_pc     = id_valid ? fifo_pc[rd_ptr] : '0;
    assign imem_addr = pc[PC_W-1:2];

    assign pop  = id_valid & id_ready;
    // A response arriving in a redirect cycle belongs to the old path
    assign push = inflight & ~redirect;
    // Slots already spoken for, crediting the entry leaving this cycle
    assign occupancy = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     imem_req = ~redirect & (occupancy < OCC_W'(DEPTH));
            FLUSH:   state_d = RUN;
            default: state_d = BOOT;
        endcase
        if (redirect) begin
            state_d = FLUSH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                inflight_pc <= pc;
            end
            if (redirect) begin
                pc     <= redirect_pc & ~PC_W'(3);
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (imem_req) begin
                    pc <= pc + PC_W'(4);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Payload storage needs no reset: outputs are gated by id_valid
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_insn[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]   <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: the model is the program-order stream of
// {pc, word(pc)} from the latest start address, consumed on each handshake.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_insc;
    logic [7:0]  id_pc;
    logic [7:0]  pc;

    int n_tests = 0;
    int n_fail  = 0;
    int hs_count = 0;
    logic [7:0] last_hs_pc = '0;

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] insn;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] stream_pc = '0;
    logic       prev_redir = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0]  prev_pc = '0;
    logic [31:0] prev_insc = '0;

    if_fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_insc(id_insc), .id_pc(id_pc), .pc(pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [5:0] a);
        return {a, 10'h155, 10'h0AA, a};
    endfunction

    // Instruction memory: data valid only the cycle after a request, garbage otherwise
    always @(posedge clk) begin
        imem_rdata <= imem_req ? mem_word(imem_addr) : $urandom();
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            stream_pc  = 8'h00;
            prev_redir = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_redir) begin
                check("valid_after_redirect", 32'(id_valid), 32'd0);
                check("no_req_in_flush", 32'(imem_req), 32'd0);
            end
            if (prev_stall) begin
                check("stall_valid_held", 32'(id_valid), 32'd1);
                check("stall_pc_held", 32'(id_pc), 32'(prev_pc));
                check("stall_insc_held", id_insc, prev_insc);
            end
            if (!id_valid) begin
                check("empty_outputs_zero", id_insc | 32'(id_pc), 32'd0);
            end
            if (imem_req) begin
                check("imem_addr", 32'(imem_addr), 32'(pc[7:2]));
            end
            if (id_valid && id_ready) begin
                exp_t e;
                if (exp_q.size() == 0) begin
                    exp_q.push_back('{pc: stream_pc, insn: mem_word(stream_pc[7:2])});
                    stream_pc = stream_pc + 8'd4;
                end
                e = exp_q.pop_front();
                check("hs_pc", 32'(id_pc), 32'(e.pc));
                check("hs_insc", id_insc, e.insn);
                last_hs_pc = id_pc;
                hs_count++;
            end
            if (redirect) begin
                exp_q.delete();
                stream_pc = redirect_pc & 8'hFC;
            end
            prev_redir = redirect;
            prev_stall = id_valid && !id_ready && !redirect;
            prev_pc    = id_pc;
            prev_insc  = id_insc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        redirect = 1'b0;
        repeat (3) tick();
        check("rst_pc", 32'(pc), 32'h00);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(id_valid), 32'd0);
        check("rst_outs", id_insc | 32'(id_pc), 32'd0);
        rst_n = 1'b1;
    endtask

    // Count cycles from reset release to first request and first valid
    task automatic startup_check();
        int first_req = 0;
        int first_val = 0;
        int vcnt = 0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (imem_req && first_req == 0) first_req = n;
            if (id_valid) begin
                first_val = n;
                break;
            end
        end
        check("first_req_cycle", 32'(first_req), 32'd1);
        check("first_valid_cycle", 32'(first_val), 32'd3);
        repeat (8) begin
            if (id_valid) vcnt++;
            tick();
        end
        check("throughput", 32'(vcnt), 32'd8);
    endtask

    task automatic pulse_redirect(input logic [7:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        tick();
        redirect = 1'b0;
    endtask

    initial begin
        int found;
        int hs_before;

        // Straight-line fetch from reset
        id_ready = 1'b1;
        do_reset();
        startup_check();

        // Decode stall fills the FIFO and freezes fetch
        id_ready = 1'b0;
        do_reset();
        repeat (6) tick();
        check("stall_no_req", 32'(imem_req), 32'd0);
        check("stall_pc", 32'(pc), 32'h08);
        check("stall_head_valid", 32'(id_valid), 32'd1);
        check("stall_head_pc", 32'(id_pc), 32'h00);
        id_ready = 1'b1;
        repeat (6) tick();

        // Redirect with a request in flight
        found = 0;
        for (int n = 0; n < 20; n++) begin
            if (imem_req) begin
                found = 1;
                break;
            end
            tick();
        end
        check("found_req", 32'(found), 32'd1);
        tick();
        pulse_redirect(8'h41);
        check("flush_req", 32'(imem_req), 32'd0);
        check("flush_valid", 32'(id_valid), 32'd0);
        tick();
        check("redir_req", 32'(imem_req), 32'd1);
        check("redir_addr", 32'(imem_addr), 32'h10);
        repeat (4) tick();

        // Wrap-around at the top of the address space
        pulse_redirect(8'hF8);
        repeat (10) tick();

        // Redirect coincident with the handshake of 0x0C
        pulse_redirect(8'h00);
        found = 0;
        for (int n = 0; n < 30; n++) begin
            if (id_valid && id_pc == 8'h0C) begin
                found = 1;
                break;
            end
            tick();
        end
        check("found_0c", 32'(found), 32'd1);
        pulse_redirect(8'h80);
        check("coinc_consumed", 32'(last_hs_pc), 32'h0C);
        check("coinc_empty", 32'(id_valid), 32'd0);
        repeat (5) tick();

        // Asynchronous reset mid-stream
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_pc", 32'(pc), 32'h00);
        check("async_rst_valid", 32'(id_valid), 32'd0);
        check("async_rst_req", 32'(imem_req), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        startup_check();

        // Randomized back-pressure and redirects
        hs_before = hs_count;
        repeat (400) begin
            id_ready    = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = 8'($urandom());
            tick();
        end
        redirect = 1'b0;
        id_ready = 1'b1;
        repeat (10) tick();
        check("random_progress", 32'((hs_count - hs_before) > 50), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
